// File: rtl/i2c_reg_target_if.sv
// I2C pin bundle between a bus master model and the register target.
// The target samples scl_i/sda_i and pulls the lines low through the *_oe outputs.
interface i2c_reg_target_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;
  logic scl_oe;

  modport master (output scl_i, output sda_i, input sda_oe, input scl_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe, output scl_oe);
endinterface

// File: rtl/i2c_reg_target.sv
// I2C target with a pointer-addressed register bank; pin-to-decision latency 3 clk.
// No backpressure on the SoC side; the I2C side can be held off by SCL stretching.
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NREGS    = 16,
  parameter int         PTR_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  i2c_reg_target_if.slave  bus,
  input  logic             stretch,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, IGNORE
  } state_t;

  state_t           state;
  logic             scl_s1, scl_s2, scl_s3;
  logic             sda_s1, sda_s2, sda_s3;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift;
  logic             rw;
  logic [PTR_W-1:0] ptr;
  logic             sda_oe_q;
  logic             scl_oe_q;
  logic [7:0]       regs [NREGS];

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  assign scl_rise  = scl_s2 & ~scl_s3;
  assign scl_fall  = ~scl_s2 & scl_s3;
  assign start_det = scl_s2 & scl_s3 & ~sda_s2 & sda_s3;
  assign stop_det  = scl_s2 & scl_s3 & sda_s2 & ~sda_s3;
  assign byte_in   = {shift[6:0], sda_s2};

  assign bus.sda_oe = sda_oe_q;
  assign bus.scl_oe = scl_oe_q;
  assign rd_data    = regs[rd_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Synchronisers reset to the idle (released) bus level so no false START is seen.
      scl_s1    <= 1'b1;
      scl_s2    <= 1'b1;
      scl_s3    <= 1'b1;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      sda_s3    <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      rw        <= 1'b0;
      ptr       <= '0;
      sda_oe_q  <= 1'b0;
      scl_oe_q  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
      busy      <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      scl_s1    <= bus.scl_i;
      scl_s2    <= scl_s1;
      scl_s3    <= scl_s2;
      sda_s1    <= bus.sda_i;
      sda_s2    <= sda_s1;
      sda_s3    <= sda_s2;
      wr_strobe <= 1'b0;
      // Only start pulling once SCL has been low in both synchroniser stages.
      scl_oe_q  <= stretch && !scl_s1 && !scl_s2 && state != IDLE && state != IGNORE;

      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        bit_cnt  <= 4'd0;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR, PTR, WDATA: begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              case (state)
                ADDR: begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                    state <= ADDR_ACK;
                    busy  <= 1'b1;
                    rw    <= byte_in[0];
                  end else begin
                    state <= IGNORE;
                  end
                end
                PTR: begin
                  ptr   <= byte_in[PTR_W-1:0];
                  state <= PTR_ACK;
                end
                default: begin
                  regs[ptr] <= byte_in;
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                  wr_data   <= byte_in;
                  ptr       <= ptr + 1'b1;
                  state     <= WACK;
                end
              endcase
            end
          end
          RDATA: begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= RACK;
          end
          ADDR_ACK, PTR_ACK, WACK: bit_cnt <= 4'd0;
          RACK: begin
            bit_cnt <= 4'd0;
            if (!sda_s2) begin
              ptr <= ptr + 1'b1;
            end else begin
              state <= IGNORE;
              busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        // bit_cnt==8 marks the low phase leading into the ACK slot; 0 marks the one after it.
        case (state)
          ADDR_ACK, PTR_ACK, WACK: begin
            if (bit_cnt == 4'd8) begin
              sda_oe_q <= 1'b1;
            end else if (state == ADDR_ACK && rw) begin
              state    <= RDATA;
              shift    <= regs[ptr];
              sda_oe_q <= !regs[ptr][7];
            end else begin
              state    <= (state == ADDR_ACK) ? PTR : WDATA;
              sda_oe_q <= 1'b0;
            end
          end
          RDATA: begin
            if (bit_cnt != 4'd0) begin
              shift    <= {shift[6:0], 1'b0};
              sda_oe_q <= !shift[6];
            end
          end
          RACK: begin
            if (bit_cnt == 4'd8) begin
              sda_oe_q <= 1'b0;
            end else begin
              state    <= RDATA;
              shift    <= regs[ptr];
              sda_oe_q <= !regs[ptr][7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
